// File: rtl/demux1to8_dist.sv
// 1-to-8 registered distributor: routes one valid/ready word per cycle to an addressed or round-robin lane.
// Optional build macro DEMUX_STATS_EN adds acc_cnt (accepted words, wrapping) and stall_cnt (stalled cycles, saturating).
//
// Per-lane state table
//   state | meaning
//   EMPTY | lane holds no pending word; out_data keeps its last value
//   FULL  | lane holds a word waiting for its consumer's out_ready
module demux1to8_dist #(
   parameter int DW    = 3,
   parameter int NLANE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DW-1:0]         in_data,
   input  logic [2:0]            in_sel,
   input  logic                  mode_rr,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [NLANE*DW-1:0]   out_data,
   output logic [NLANE-1:0]      out_valid,
   input  logic [NLANE-1:0]      out_ready,
   output logic [2:0]            last_lane
`ifdef DEMUX_STATS_EN
   ,
   output logic [7:0]            acc_cnt,
   output logic [7:0]            stall_cnt
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_st_t;

   lane_st_t          st_q [NLANE];
   lane_st_t          st_d [NLANE];
   logic [NLANE-1:0]  load;
   logic [2:0]        rr_ptr;
   logic [2:0]        tgt;
   logic              accept;

   assign tgt      = mode_rr ? rr_ptr : in_sel;
   // Pass-through: a full lane being drained this cycle can take a new word.
   assign in_ready = ~out_valid[tgt] | out_ready[tgt];
   assign accept   = in_valid & in_ready;

   always_comb begin
      load      = '0;
      out_valid = '0;
      for (int k = 0; k < NLANE; k++) begin
         st_d[k]      = st_q[k];
         out_valid[k] = (st_q[k] == FULL);
         if (accept && (tgt == 3'(k))) begin
            st_d[k] = FULL;
            load[k] = 1'b1;
         end else if ((st_q[k] == FULL) && out_ready[k]) begin
            st_d[k] = EMPTY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NLANE; k++) st_q[k] <= EMPTY;
         out_data  <= '0;
         last_lane <= '0;
         rr_ptr    <= '0;
      end else begin
         for (int k = 0; k < NLANE; k++) begin
            st_q[k] <= st_d[k];
            if (load[k]) out_data[k*DW +: DW] <= in_data;
         end
         if (accept) begin
            last_lane <= tgt;
            // Pointer only advances on RR accepts; held across addressed traffic.
            if (mode_rr) rr_ptr <= rr_ptr + 3'd1;
         end
      end
   end

`ifdef DEMUX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (accept) acc_cnt <= acc_cnt + 8'd1;
         if (in_valid && !in_ready && (stall_cnt != 8'hFF)) stall_cnt <= stall_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_demux1to8_dist.sv
// Self-checking bench for demux1to8_dist: directed scenarios plus randomized traffic
// compared against a lane-array reference model.
module tb_demux1to8_dist;

   logic        clk;
   logic        rst_n;
   logic [2:0]  in_data;
   logic [2:0]  in_sel;
   logic        mode_rr;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] out_data;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic [2:0]  last_lane;
`ifdef DEMUX_STATS_EN
   logic [7:0]  acc_cnt;
   logic [7:0]  stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // reference model: what each lane holds, where the RR pointer is, what was last loaded
   bit          m_full [8];
   logic [2:0]  m_word [8];
   int          m_ptr;
   int          m_last;
   int          m_acc;
   int          m_stall;

   demux1to8_dist #(.DW(3), .NLANE(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .mode_rr   (mode_rr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .last_lane (last_lane)
`ifdef DEMUX_STATS_EN
      ,
      .acc_cnt   (acc_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_tgt();
      return mode_rr ? m_ptr : int'(in_sel);
   endfunction

   function automatic logic m_ready();
      int t = m_tgt();
      return (!m_full[t]) || out_ready[t];
   endfunction

   function automatic logic [7:0] m_valid();
      logic [7:0] v;
      for (int k = 0; k < 8; k++) v[k] = m_full[k];
      return v;
   endfunction

   function automatic logic [23:0] m_data();
      logic [23:0] d;
      for (int k = 0; k < 8; k++) d[k*3 +: 3] = m_word[k];
      return d;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 8; k++) begin
         m_full[k] = 1'b0;
         m_word[k] = 3'd0;
      end
      m_ptr = 0; m_last = 0; m_acc = 0; m_stall = 0;
   endtask

   // one clock cycle: inputs already driven; model follows the same edge
   task automatic tick();
      int   t   = m_tgt();
      logic acc = in_valid && m_ready();
      @(posedge clk);
      for (int k = 0; k < 8; k++)
         if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
      if (acc) begin
         m_full[t] = 1'b1;
         m_word[t] = in_data;
         m_last    = t;
         if (mode_rr) m_ptr = (m_ptr + 1) % 8;
         m_acc = (m_acc + 1) % 256;
      end else if (in_valid && m_stall < 255) begin
         m_stall++;
      end
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n = 1'b0;
      m_reset();
      #3;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 3'd0; in_sel = 3'd0; mode_rr = 1'b0; out_ready = 8'h00;
      m_reset();
      #12;
      total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_init_valid got=%h exp=00", out_valid); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      // fill lanes 2 and 5 with no consumers ready
      in_valid = 1'b1; in_sel = 3'd2; in_data = 3'b111; tick();
      in_sel = 3'd5; in_data = 3'b011; tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 8'h24) begin bad++; $display("FAIL reset_prefill got=%h exp=24", out_valid); end
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_async_valid got=%h exp=00", out_valid); end
      total++; if (out_data !== 24'h0) begin bad++; $display("FAIL reset_async_data got=%h exp=000000", out_data); end
      total++; if (last_lane !== 3'd0) begin bad++; $display("FAIL reset_async_last got=%0d exp=0", last_lane); end
      rst_n = 1'b1;
   endtask

   task automatic test_addressed();
      mode_rr = 1'b0; out_ready = 8'hFF;
      in_valid = 1'b1; in_sel = 3'd3; in_data = 3'b101;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addr_ready got=%b exp=1", in_ready); end
      tick();
      total++; if (out_valid !== 8'h08) begin bad++; $display("FAIL addr_valid3 got=%h exp=08", out_valid); end
      total++; if (out_data[9 +: 3] !== 3'd5) begin bad++; $display("FAIL addr_data3 got=%0d exp=5", out_data[9 +: 3]); end
      total++; if (last_lane !== 3'd3) begin bad++; $display("FAIL addr_last3 got=%0d exp=3", last_lane); end
      in_sel = 3'd6; in_data = 3'b010;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 8'h40) begin bad++; $display("FAIL addr_valid6 got=%h exp=40", out_valid); end
      total++; if (out_data[18 +: 3] !== 3'd2) begin bad++; $display("FAIL addr_data6 got=%0d exp=2", out_data[18 +: 3]); end
      total++; if (last_lane !== 3'd6) begin bad++; $display("FAIL addr_last6 got=%0d exp=6", last_lane); end
      tick();
   endtask

   task automatic test_backpressure();
      mode_rr = 1'b0; out_ready = 8'hFD;
      in_valid = 1'b1; in_sel = 3'd1; in_data = 3'b011;
      tick();
      in_data = 3'b110;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%b exp=0", in_ready); end
      tick();
      total++; if (out_data[3 +: 3] !== 3'b011 || out_valid[1] !== 1'b1) begin
         bad++; $display("FAIL bp_hold got=%0d/%b exp=3/1", out_data[3 +: 3], out_valid[1]); end
      out_ready[1] = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_pass_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      total++; if (out_data[3 +: 3] !== 3'b110 || out_valid[1] !== 1'b1) begin
         bad++; $display("FAIL bp_pass_load got=%0d/%b exp=6/1", out_data[3 +: 3], out_valid[1]); end
      tick();
      total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL bp_drain got=%h exp=00", out_valid); end
   endtask

   task automatic test_rr_wrap();
      do_reset();
      mode_rr = 1'b1; out_ready = 8'hFF; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 3'(i % 8);
         in_sel  = 3'($urandom_range(0, 7));
         tick();
         total++; if (last_lane !== 3'(i % 8) || out_valid !== (8'h01 << (i % 8)) || out_data[(i % 8)*3 +: 3] !== 3'(i % 8)) begin
            bad++; $display("FAIL rr_wrap_%0d got lane=%0d valid=%h exp lane=%0d", i, last_lane, out_valid, i % 8); end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_rr_stall();
      // pointer sits at 2 after the wrap; two more RR words bring it to 4
      mode_rr = 1'b1; out_ready = 8'hFF; in_valid = 1'b1; in_data = 3'd4;
      tick();
      total++; if (last_lane !== 3'd2) begin bad++; $display("FAIL rr_resume got=%0d exp=2", last_lane); end
      tick();
      mode_rr = 1'b0; in_sel = 3'd4; out_ready = 8'hEF; in_data = 3'd1;
      tick();
      mode_rr = 1'b1; in_data = 3'd7; in_sel = 3'd0;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rr_stall_ready got=%b exp=0", in_ready); end
      tick(); tick();
      total++; if (out_valid[5] !== 1'b0 || last_lane !== 3'd4 || out_data[12 +: 3] !== 3'd1) begin
         bad++; $display("FAIL rr_stall_hold got v5=%b last=%0d d4=%0d exp 0/4/1", out_valid[5], last_lane, out_data[12 +: 3]); end
      out_ready[4] = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rr_release_ready got=%b exp=1", in_ready); end
      tick();
      total++; if (last_lane !== 3'd4 || out_data[12 +: 3] !== 3'd7) begin
         bad++; $display("FAIL rr_release_load got last=%0d d4=%0d exp 4/7", last_lane, out_data[12 +: 3]); end
      in_data = 3'd2;
      tick();
      total++; if (last_lane !== 3'd5) begin bad++; $display("FAIL rr_after_stall got=%0d exp=5", last_lane); end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_mode_switch();
      // pointer is now 6
      mode_rr = 1'b0; in_sel = 3'd0; out_ready = 8'hFF; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 3'(i + 1);
         tick();
         total++; if (last_lane !== 3'd0 || out_data[2:0] !== 3'(i + 1)) begin
            bad++; $display("FAIL ms_addr_%0d got last=%0d d0=%0d exp 0/%0d", i, last_lane, out_data[2:0], i + 1); end
      end
      mode_rr = 1'b1; in_sel = 3'd3; in_data = 3'd6;
      tick();
      in_valid = 1'b0;
      total++; if (last_lane !== 3'd6) begin bad++; $display("FAIL ms_rr_resume got=%0d exp=6", last_lane); end
`ifdef DEMUX_STATS_EN
      total++; if (int'(acc_cnt) !== m_acc) begin bad++; $display("FAIL ms_acc_cnt got=%0d exp=%0d", acc_cnt, m_acc); end
      total++; if (int'(stall_cnt) !== m_stall) begin bad++; $display("FAIL ms_stall_cnt got=%0d exp=%0d", stall_cnt, m_stall); end
`endif
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         mode_rr   = ($urandom_range(0, 1) == 1);
         in_sel    = 3'($urandom_range(0, 7));
         in_data   = 3'($urandom_range(0, 7));
         out_ready = 8'($urandom_range(0, 255));
         #1;
         total++; if (in_ready !== m_ready()) begin
            bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, m_ready()); end
         tick();
         total++; if (out_valid !== m_valid() || out_data !== m_data() || last_lane !== 3'(m_last)) begin
            bad++; $display("FAIL rnd_state c=%0d got v=%h d=%h l=%0d exp v=%h d=%h l=%0d",
                            c, out_valid, out_data, last_lane, m_valid(), m_data(), m_last); end
`ifdef DEMUX_STATS_EN
         total++; if (int'(acc_cnt) !== m_acc || int'(stall_cnt) !== m_stall) begin
            bad++; $display("FAIL rnd_stats c=%0d got %0d/%0d exp %0d/%0d", c, acc_cnt, stall_cnt, m_acc, m_stall); end
`endif
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_addressed();
      test_backpressure();
      test_rr_wrap();
      test_rr_stall();
      test_mode_switch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux1to8_dist.md
Name: demux1to8_dist

Overview:
- Sequential 1-to-8 distributor: the opposite direction of the team's 8-to-1 3-bit mux tree.
- Accepts one 3-bit word per cycle on a valid/ready input and routes it to one of eight registered output lanes.
- The lane is picked either by an explicit 3-bit select or by an internal round-robin pointer.
- Each lane holds one word until its consumer takes it, so the block absorbs per-lane back-pressure.

Parameters:
- DW, 3, data width of the input word and of each lane.
- NLANE, 8, number of output lanes; fixed at 8, since the select is 3 bits.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_data  input  DW  word to distribute.
- in_sel  input  3  target lane when mode_rr=0; bit 2 is the MSB (lanes 0-3 low half, 4-7 high half).
- mode_rr  input  1  1 = round-robin routing, 0 = addressed routing via in_sel.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block accepts the word this cycle (combinational).
- out_data  output  NLANE*DW  flattened lane registers; lane k occupies bits [k*DW +: DW].
- out_valid  output  NLANE  per-lane word present.
- out_ready  input  NLANE  per-lane consumer accepts.
- last_lane  output  3  index of the lane that received the most recent accepted word.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, last_lane=0, rr_ptr=0. Outputs are held there until the first clk edge after rst_n rises.
- Target lane: tgt = mode_rr ? rr_ptr : in_sel. Evaluated combinationally every cycle.
- in_ready = ~out_valid[tgt] | out_ready[tgt].
  - Pass-through: a full lane being drained in the same cycle still accepts.
  - in_ready may depend combinationally on out_ready; there is no combinational path from in_valid to in_ready.
- Accept = in_valid & in_ready. On accept, at the clock edge:
  - out_data lane tgt <= in_data;
  - out_valid[tgt] <= 1;
  - last_lane <= tgt.
- Per-lane two-state machine:
  - EMPTY -> FULL on accept to this lane.
  - FULL -> EMPTY on out_ready with no accept to this lane that cycle.
  - FULL -> FULL (data replaced) on out_ready plus accept in the same cycle.
  - FULL stays FULL with data stable while out_ready=0.
- Lane data does not change while out_valid=1 and out_ready=0 (AXI-style stability).
- Latency: accepted word appears on its lane the cycle after the accept edge. Throughput is one word per cycle when targets are free.
- Only the target lane is loaded per cycle. Other lanes drain independently and concurrently.
- Round-robin:
  - rr_ptr increments by 1 only on an accept while mode_rr=1, wrapping 7 -> 0.
  - Stall (in_ready=0) leaves rr_ptr unchanged. There is no skipping of full lanes; strict order is kept.
- Mode switch: rr_ptr is retained while mode_rr=0 and resumes from its held value when mode_rr returns to 1. in_sel is ignored in RR mode.
- in_valid=0: no state change except lane drains.
- Reset mid-operation: pending lane words are discarded, all lanes go EMPTY, and rr_ptr returns to 0 immediately (asynchronous).
- out_data of an EMPTY lane holds its last value (0 after reset). Consumers qualify it with out_valid.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined: adds output port acc_cnt [7:0].
  - acc_cnt is a count of accepted input words, reset 0, +1 per accept, wrapping 255 -> 0.
  - Adds output stall_cnt [7:0]: cycles with in_valid=1 & in_ready=0, saturating at 255.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

Test Plan:
- Reset check: assert rst_n=0 mid-run with lanes 2 and 5 FULL -> out_valid=8'h00, out_data=0, last_lane=0 immediately, without a clock edge.
- Addressed routing: mode_rr=0, all out_ready=1; send (in_sel=3, data=3'b101) then (in_sel=6, data=3'b010) -> lane 3 valid with 5 the cycle after the first accept, then lane 6 valid with 2; last_lane=3 then 6.
- Back-pressure and pass-through:
  - out_ready[1]=0, send two words to lane 1 -> first accepted, second sees in_ready=0 and lane 1 holds the first word stable.
  - Raise out_ready[1] -> in_ready=1 the same cycle; second word loads and out_valid[1] stays 1.
- Round-robin wrap: mode_rr=1, all ready, 10 back-to-back words 0..7,0,1 -> lanes 0..7,0,1 in order; rr_ptr=2 at the end.
- RR stall: mode_rr=1, rr_ptr=4, lane 4 FULL with out_ready[4]=0 -> in_ready=0 and rr_ptr stays 4 (lane 5 not used); release out_ready[4] -> word goes to lane 4 and rr_ptr=5.
- Mode switch: in RR mode leave rr_ptr=6, switch to mode_rr=0 and send 3 words to in_sel=0, return to RR -> next word lands on lane 6. With DEMUX_STATS_EN, acc_cnt increments once per accepted word.
